// File: rtl/mult_sequencer_if.sv
// Handshake and operand/result bundle between control decode and the
// multi-cycle multiply sequencer.
interface mult_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic             Square;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             Busy;
    logic             Stall;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic             Overflow;

    // Control decode side: issues requests, consumes results.
    modport master (
        output Start, Square, OperandA, OperandB,
        input  Busy, Stall, Done, Result, ResultHi, Overflow
    );

    // Sequencer side.
    modport slave (
        input  Start, Square, OperandA, OperandB,
        output Busy, Stall, Done, Result, ResultHi, Overflow
    );
endinterface

// File: rtl/mult_sequencer.sv
// Multi-cycle unsigned shift-add multiplier for MULT/SQU. Runs a fixed WIDTH
// iterations, stalls the pipeline while running, then pulses Done for one
// cycle with the registered product.
module mult_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    mult_sequencer_if.slave   bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 overflow_q, overflow_d;
    logic [2*WIDTH-1:0]   sum;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state and datapath: capture on issue, one shift-add step per RUN cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        overflow_d  = overflow_q;
        sum         = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.OperandA};
                    mplier_d = bus.Square ? bus.OperandA : bus.OperandB;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CntW'(1);
                // Last iteration: publish the final sum straight into the result registers.
                if (count_q == LastCount) begin
                    state_d     = StDone;
                    result_d    = sum[WIDTH-1:0];
                    result_hi_d = sum[2*WIDTH-1:WIDTH];
                    overflow_d  = |sum[2*WIDTH-1:WIDTH];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs; the IDLE term of Stall is combinational so the issue cycle freezes too.
    always_comb begin
        bus.Busy     = (state_q == StRun) || (state_q == StDone);
        bus.Stall    = ((state_q == StIdle) && bus.Start) || (state_q == StRun);
        bus.Done     = (state_q == StDone);
        bus.Result   = result_q;
        bus.ResultHi = result_hi_q;
        bus.Overflow = overflow_q;
    end
endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed corner cases plus randomized
// operations compared against an arithmetic reference product and cycle model.
module tb_mult_sequencer;
    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mult_sequencer_if #(.WIDTH(W)) bus ();

    mult_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Architecturally visible result the model expects to be held.
    logic [W-1:0] exp_lo = '0;
    logic [W-1:0] exp_hi = '0;
    logic         exp_ov = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit busy, input bit stall, input bit done);
        check_val({tag, ".busy"},  64'(bus.Busy),     64'(busy));
        check_val({tag, ".stall"}, 64'(bus.Stall),    64'(stall));
        check_val({tag, ".done"},  64'(bus.Done),     64'(done));
        check_val({tag, ".lo"},    64'(bus.Result),   64'(exp_lo));
        check_val({tag, ".hi"},    64'(bus.ResultHi), 64'(exp_hi));
        check_val({tag, ".ov"},    64'(bus.Overflow), 64'(exp_ov));
    endtask

    // mode 0: quiet inputs; 1: random garbage on all inputs while busy;
    // 2: zero the operands and pulse Start in cycle 5.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sq,
                         input int mode);
        logic [63:0] prod;
        prod = 64'(a) * 64'(sq ? a : b);
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Square   = sq;
        bus.OperandA = a;
        bus.OperandB = b;
        #1;
        check_outs("issue", 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= int'(W) + 1; c++) begin
            @(negedge clk);
            if (mode == 1) begin
                bus.Start    = 1'($urandom_range(0, 1));
                bus.Square   = 1'($urandom_range(0, 1));
                bus.OperandA = $urandom;
                bus.OperandB = $urandom;
            end else if (mode == 2 && c == 5) begin
                bus.OperandA = '0;
                bus.OperandB = '0;
                bus.Start    = 1'b1;
            end else begin
                bus.Start = 1'b0;
            end
            #1;
            if (c == int'(W) + 1) begin
                exp_lo = prod[W-1:0];
                exp_hi = prod[2*W-1:W];
                exp_ov = |prod[2*W-1:W];
                check_outs("done", 1'b1, 1'b0, 1'b1);
            end else begin
                check_outs("run", 1'b1, 1'b1, 1'b0);
            end
        end
        @(negedge clk);
        bus.Start = 1'b0;
        #1;
        check_outs("idle", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.Start    = 1'b0;
        bus.Square   = 1'b0;
        bus.OperandA = '0;
        bus.OperandB = '0;

        #2 reset = 1'b0;
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_outs("post_reset", 1'b0, 1'b0, 1'b0);

        do_op(32'd3, 32'd5, 1'b0, 0);
        do_op(32'h0000_FFFF, 32'hDEAD_BEEF, 1'b1, 0);
        do_op(32'd0, 32'h1234_5678, 1'b0, 0);
        do_op(32'h0001_0000, 32'h0001_0000, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

        // Start/operand isolation: result must be 7*6 and no second run follows.
        do_op(32'd7, 32'd6, 1'b0, 2);
        check_val("iso.result", 64'(exp_lo), 64'd42);
        for (int i = 0; i < int'(W) + 4; i++) begin
            @(negedge clk);
            #1;
            check_outs("iso_hold", 1'b0, 1'b0, 1'b0);
        end

        // Reset in cycle 10 of a run aborts it and clears the results.
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Square   = 1'b0;
        bus.OperandA = 32'h1234;
        bus.OperandB = 32'h55;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.Start = 1'b0;
        end
        reset  = 1'b0;
        exp_lo = '0;
        exp_hi = '0;
        exp_ov = 1'b0;
        #1;
        check_outs("rst_run", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < int'(W) + 4; i++) begin
            @(negedge clk);
            #1;
            check_outs("rst_quiet", 1'b0, 1'b0, 1'b0);
        end
        do_op(32'd2, 32'd9, 1'b0, 0);
        check_val("after_rst.result", 64'(exp_lo), 64'd18);

        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (n % 4 == 0) ra = ra >> $urandom_range(0, W - 1);
            do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle sequencer for the MULT and SQU instructions, which the single-cycle ALU cannot complete in one clock. When the control unit decodes one of these instructions, it raises `Start`. The block then runs an unsigned shift-add multiply over `WIDTH` iterations. While it runs, it holds the PC and register-file write enable frozen through `Stall`. It then presents the product for a one-cycle write-back.

## Interface
- `WIDTH`, default 32: operand width. The internal product is 2*`WIDTH` bits.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request from control decode, valid MULT/SQU in the current instruction.
- `Square`  in  1  1 = SQU (multiplier := `OperandA`, `OperandB` ignored); 0 = MULT.
- `OperandA`  in  `WIDTH`  multiplicand (rs data).
- `OperandB`  in  `WIDTH`  multiplier (rt data).
- `Busy`  out  1  high in RUN and DONE.
- `Stall`  out  1  freezes PC and RegWrite.
- `Done`  out  1  one-cycle pulse; `Result` is valid for write-back.
- `Result`  out  `WIDTH`  low half of the product.
- `ResultHi`  out  `WIDTH`  high half of the product.
- `Overflow`  out  1  `ResultHi` != 0.

## Operation
- States are IDLE, RUN and DONE. Encoding is free, but there must be no unreachable lockup states; any illegal state goes to IDLE.
- **IDLE**
  - If `Start`=1, on the next edge:
    - mcand[2W-1:0] := zero-extended `OperandA`.
    - mplier := `Square` ? `OperandA` : `OperandB`.
    - acc := 0.
    - count := 0.
    - Go to RUN.
  - If `Start`=0, stay in IDLE.
- **RUN**, per cycle:
  - If mplier[0], acc := acc + mcand (2W-bit add, no carry out possible).
  - mcand := mcand << 1.
  - mplier := mplier >> 1.
  - count := count + 1.
  - When count == `WIDTH`-1 in this cycle, go to DONE.
  - There is no early termination: latency is fixed regardless of operand values.
- **DONE**
  - `Done`=1.
  - {`ResultHi`,`Result`} := acc.
  - `Overflow` := |acc[2W-1:W].
  - Next edge goes to IDLE.
- `Start` is sampled only in IDLE. `Start` in RUN or DONE is ignored and never queues a second operation.
- Operands are captured at the IDLE->RUN edge only. Later changes on `OperandA`/`OperandB`/`Square` have no effect.
- `Result`/`ResultHi`/`Overflow` are registered.
  - They update at the RUN->DONE edge.
  - They hold until the next RUN->DONE edge or reset.
- All arithmetic is unsigned. The product is computed modulo 2^(2W), which is exact for W-bit unsigned operands.

## Timing
- Reset (asynchronous, `reset`=0):
  - State = IDLE.
  - acc, mcand, mplier and count are 0.
  - `Busy`=0, `Stall`=0, `Done`=0.
  - `Result`=0, `ResultHi`=0, `Overflow`=0.
- Reset during RUN or DONE aborts the operation immediately. No `Done` is produced, and the first post-reset cycle is IDLE.
- `Stall` = (IDLE & `Start`) | RUN. It is combinational on the IDLE term, so the issuing cycle itself is frozen.
- Cycle numbering, with cycle 0 as the IDLE cycle where `Start`=1:
  - Cycles 1..`WIDTH` are RUN.
  - Cycle `WIDTH`+1 is DONE: `Done`=1 and `Stall`=0, so the datapath writes `Result` back and advances the PC.
  - Cycle `WIDTH`+2 is IDLE.
- Latency from `Start` to `Done` is `WIDTH`+1 cycles (33 for `WIDTH`=32). `Stall` is high for `WIDTH`+1 cycles (0..`WIDTH`).
- Back-to-back operations: the next MULT issues no earlier than cycle `WIDTH`+2. Throughput is one operation per `WIDTH`+2 cycles.
- `Done` is never high for two consecutive cycles.

## Test plan
- **Reset and basic MULT.** Hold `reset`=0, then release. All outputs must be 0. Then `Start`=1, `Square`=0, A=3, B=5 with `WIDTH`=32.
  - `Stall` must be high in cycles 0..32.
  - `Done` must pulse in cycle 33 with `Result`=15, `ResultHi`=0, `Overflow`=0.
- **SQU.** `Square`=1, A=0x0000FFFF, B=0xDEADBEEF. Required: `Result`=0xFFFE0001, `ResultHi`=0, `Overflow`=0. This confirms B is ignored.
- **Overflow and all-ones.**
  - A=0x00010000, B=0x00010000 -> `Result`=0, `ResultHi`=1, `Overflow`=1.
  - A=B=0xFFFFFFFF -> `Result`=0x00000001, `ResultHi`=0xFFFFFFFE.
- **Operand and start isolation.** Start with A=7, B=6. In cycle 5, change A/B to 0 and pulse `Start`. Required:
  - A single `Done` in cycle 33 with `Result`=42.
  - No second operation afterwards.
  - `Result` holds 42 until the next completion.
- **Zero operand and reset mid-run.**
  - A=0, B=0x12345678 -> `Result`=0, with `Done` still in cycle 33.
  - A second run with reset asserted in cycle 10: IDLE immediately, all outputs 0, no `Done`, and a subsequent 2*9 returns 18.
